// File: rtl/multicycle_control.sv
// multicycle_control: Moore controller that sequences a multicycle MIPS datapath.
// It emits every datapath select and enable, and it keeps a retired-instruction
// counter and a sticky illegal-opcode flag.
// Optional feature: define MULTICYCLE_MEM_WAIT_EN to make FETCH, MEM_READ and
// MEM_WRITE wait for mem_ready.
//
// state     | meaning
// ----------+--------------------------------------------------
// FETCH     | read instruction at PC, load IR, PC <- PC + 4
// DECODE    | read registers, precompute branch target
// MEM_ADDR  | ALUOut <- A + sign-ext imm (lw/sw address)
// MEM_READ  | read data memory at ALUOut into MDR
// MEM_WB    | rt <- MDR
// MEM_WRITE | write B to data memory at ALUOut
// R_EXEC    | ALUOut <- A funct B
// R_WB      | rd <- ALUOut
// BRANCH    | PC <- target if A == B
// JUMP      | PC <- jump target
// ADDI_EXEC | ALUOut <- A + sign-ext imm
// ADDI_WB   | rt <- ALUOut
module multicycle_control #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_source,
    output logic               ior_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [3:0]         state,
    output logic [COUNT_W-1:0] retired,
    output logic               illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t cur_state;
    state_t next_state;
    logic   mem_done;
    logic   retire_now;
    logic   illegal_now;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_done = 1'b1;
`endif

    assign state = cur_state;

    // State register, retired counter and sticky illegal flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_state  <= S_FETCH;
            retired    <= '0;
            illegal_op <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (retire_now)
                retired <= retired + {{(COUNT_W-1){1'b0}}, 1'b1};
            if (illegal_now)
                illegal_op <= 1'b1;
        end
    end

    // Next-state logic; opcode only matters in DECODE and MEM_ADDR
    always_comb begin
        next_state  = S_FETCH;
        illegal_now = 1'b0;
        retire_now  = 1'b0;
        case (cur_state)
            S_FETCH:     next_state = mem_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEM_ADDR;
                    OP_RTYPE:     next_state = S_R_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDI_EXEC;
                    default: begin
                        next_state  = S_FETCH;
                        illegal_now = 1'b1;
                    end
                endcase
            end
            // Only sw goes to MEM_WRITE; anything else is treated as a load
            S_MEM_ADDR:  next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  next_state = mem_done ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB: begin
                next_state = S_FETCH;
                retire_now = 1'b1;
            end
            S_MEM_WRITE: begin
                next_state = mem_done ? S_FETCH : S_MEM_WRITE;
                retire_now = mem_done;
            end
            S_R_EXEC:    next_state = S_R_WB;
            S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                next_state = S_FETCH;
                retire_now = 1'b1;
            end
            S_ADDI_EXEC: next_state = S_ADDI_WB;
            default:     next_state = S_FETCH;
        endcase
    end

    // Moore output decode, forced inactive while reset is asserted
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        ior_d         = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        if (rst) begin
            case (cur_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    ir_write  = mem_done;
                    pc_write  = mem_done;
                    alu_src_b = 2'b01;
                end
                S_DECODE:    alu_src_b = 2'b11;
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    ior_d    = 1'b1;
                end
                S_MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    ior_d     = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_R_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ADDI_WB:   reg_write = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control. A second instance with COUNT_W=4
// shares the inputs and is used to check counter wrap.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;

    logic        pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0]  pc_source, alu_src_b, alu_op;
    logic [3:0]  state;
    logic [31:0] retired;

    logic        w_pc_write, w_pc_write_cond, w_ior_d, w_mem_read, w_mem_write, w_ir_write;
    logic        w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_src_a, w_illegal_op;
    logic [1:0]  w_pc_source, w_alu_src_b, w_alu_op;
    logic [3:0]  w_state;
    logic [3:0]  w_retired;

    int tests = 0;
    int fails = 0;
    int exp_ret = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .ior_d(ior_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state(state), .retired(retired), .illegal_op(illegal_op)
    );

    multicycle_control #(.COUNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond), .pc_source(w_pc_source),
        .ior_d(w_ior_d), .mem_read(w_mem_read), .mem_write(w_mem_write), .ir_write(w_ir_write),
        .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg), .reg_write(w_reg_write),
        .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .alu_op(w_alu_op),
        .state(w_state), .retired(w_retired), .illegal_op(w_illegal_op)
    );

    logic [15:0] ctrl;
    assign ctrl = {pc_write, pc_write_cond, pc_source, ior_d, mem_read, mem_write, ir_write,
                   reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};

    // Expected control word per state, written straight from the state table
    function automatic logic [15:0] exp_ctrl(input logic [3:0] s);
        logic [15:0] c;
        c = '0;
        case (s)
            4'd0:  begin c[15] = 1'b1; c[10] = 1'b1; c[8] = 1'b1; c[3:2] = 2'b01; end
            4'd1:  c[3:2] = 2'b11;
            4'd2:  begin c[4] = 1'b1; c[3:2] = 2'b10; end
            4'd3:  begin c[10] = 1'b1; c[11] = 1'b1; end
            4'd4:  begin c[6] = 1'b1; c[5] = 1'b1; end
            4'd5:  begin c[9] = 1'b1; c[11] = 1'b1; end
            4'd6:  begin c[4] = 1'b1; c[1:0] = 2'b10; end
            4'd7:  begin c[7] = 1'b1; c[5] = 1'b1; end
            4'd8:  begin c[4] = 1'b1; c[1:0] = 2'b01; c[14] = 1'b1; c[13:12] = 2'b01; end
            4'd9:  begin c[15] = 1'b1; c[13:12] = 2'b10; end
            4'd10: begin c[4] = 1'b1; c[3:2] = 2'b10; end
            4'd11: c[5] = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH; seq holds n state nibbles, first in [3:0]
    task automatic run_seq(input string name, input logic [5:0] op, input int n,
                           input logic [19:0] seq, input int ret_inc);
        logic [3:0] s;
        opcode = op;
        for (int i = 0; i < n; i++) begin
            s = seq[i*4 +: 4];
            tests++;
            if (state !== s) begin
                fails++;
                $display("FAIL %s state[%0d]: got %0d want %0d", name, i, state, s);
            end
            tests++;
            if (ctrl !== exp_ctrl(s)) begin
                fails++;
                $display("FAIL %s ctrl[%0d]: got %h want %h", name, i, ctrl, exp_ctrl(s));
            end
            step();
        end
        exp_ret += ret_inc;
        tests++;
        if (retired !== exp_ret[31:0]) begin
            fails++;
            $display("FAIL %s retired: got %0d want %0d", name, retired, exp_ret);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; opcode = 6'd0; mem_ready = 1'b1;
        step(); step();
        tests++;
        if (state !== 4'd0 || retired !== 32'd0 || illegal_op !== 1'b0 || ctrl !== 16'h0) begin
            fails++;
            $display("FAIL reset_init: state=%0d retired=%0d illegal=%b ctrl=%h want 0", state, retired, illegal_op, ctrl);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (ctrl !== exp_ctrl(4'd0)) begin
            fails++;
            $display("FAIL reset_release_ctrl: got %h want %h", ctrl, exp_ctrl(4'd0));
        end
        opcode = 6'b000000;
        step(); step();
        tests++;
        if (state !== 4'd6) begin
            fails++;
            $display("FAIL reset_pre_rexec: got %0d want 6", state);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (ctrl !== 16'h0) begin
            fails++;
            $display("FAIL reset_force_zero: got %h want 0", ctrl);
        end
        step(); step();
        tests++;
        if (state !== 4'd0 || retired !== 32'd0 || illegal_op !== 1'b0 || ctrl !== 16'h0) begin
            fails++;
            $display("FAIL reset_mid: state=%0d retired=%0d illegal=%b ctrl=%h want 0", state, retired, illegal_op, ctrl);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (state !== 4'd0 || mem_read !== 1'b1 || ir_write !== 1'b1 || pc_write !== 1'b1) begin
            fails++;
            $display("FAIL reset_fetch: state=%0d rd=%b irw=%b pcw=%b want 0,1,1,1", state, mem_read, ir_write, pc_write);
        end
        exp_ret = 0;
    endtask

    task automatic test_lw();
        run_seq("lw", 6'b100011, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 1);
    endtask

    task automatic test_beq_j();
        run_seq("beq", 6'b000100, 3, {8'h00, 4'd8, 4'd1, 4'd0}, 1);
        run_seq("j",   6'b000010, 3, {8'h00, 4'd9, 4'd1, 4'd0}, 1);
    endtask

    task automatic test_sw_r_addi();
        run_seq("sw",   6'b101011, 4, {4'h0, 4'd5, 4'd2, 4'd1, 4'd0}, 1);
        run_seq("rtyp", 6'b000000, 4, {4'h0, 4'd7, 4'd6, 4'd1, 4'd0}, 1);
        run_seq("addi", 6'b001000, 4, {4'h0, 4'd11, 4'd10, 4'd1, 4'd0}, 1);
    endtask

    task automatic test_illegal();
        run_seq("ill", 6'b111111, 2, {12'h000, 4'd1, 4'd0}, 0);
        tests++;
        if (illegal_op !== 1'b1) begin
            fails++;
            $display("FAIL illegal_set: got %b want 1", illegal_op);
        end
        run_seq("ill_addi", 6'b001000, 4, {4'h0, 4'd11, 4'd10, 4'd1, 4'd0}, 1);
        tests++;
        if (illegal_op !== 1'b1) begin
            fails++;
            $display("FAIL illegal_sticky: got %b want 1", illegal_op);
        end
    endtask

    task automatic test_wrap();
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_ret = 0;
        #1;
        for (int k = 0; k < 15; k++)
            run_seq("wrap_r", 6'b000000, 4, {4'h0, 4'd7, 4'd6, 4'd1, 4'd0}, 1);
        tests++;
        if (w_retired !== 4'd15) begin
            fails++;
            $display("FAIL wrap_15: got %0d want 15", w_retired);
        end
        run_seq("wrap_r", 6'b000000, 4, {4'h0, 4'd7, 4'd6, 4'd1, 4'd0}, 1);
        tests++;
        if (w_retired !== 4'd0 || retired !== 32'd16) begin
            fails++;
            $display("FAIL wrap_0: got w4=%0d w32=%0d want 0,16", w_retired, retired);
        end
    endtask

`ifdef MULTICYCLE_MEM_WAIT_EN
    task automatic test_fetch_wait();
        opcode = 6'b000000;
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (state !== 4'd0 || ir_write !== 1'b0 || pc_write !== 1'b0 || mem_read !== 1'b1) begin
                fails++;
                $display("FAIL fetch_wait[%0d]: state=%0d irw=%b pcw=%b rd=%b want 0,0,0,1", k, state, ir_write, pc_write, mem_read);
            end
            step();
        end
        mem_ready = 1'b1;
        #1;
        tests++;
        if (state !== 4'd0 || ir_write !== 1'b1 || pc_write !== 1'b1) begin
            fails++;
            $display("FAIL fetch_ready: state=%0d irw=%b pcw=%b want 0,1,1", state, ir_write, pc_write);
        end
        step();
        tests++;
        if (state !== 4'd1) begin
            fails++;
            $display("FAIL fetch_advance: got %0d want 1", state);
        end
        step(); step(); step();
    endtask

    task automatic test_sw_wait();
        run_seq("rtyp_w", 6'b000000, 4, {4'h0, 4'd7, 4'd6, 4'd1, 4'd0}, 1);
        opcode = 6'b101011;
        step(); step(); step();
        mem_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) mem_ready = 1'b1;
            #1;
            tests++;
            if (state !== 4'd5 || mem_write !== 1'b1 || retired !== exp_ret[31:0]) begin
                fails++;
                $display("FAIL sw_wait[%0d]: state=%0d wr=%b retired=%0d want 5,1,%0d", k, state, mem_write, retired, exp_ret);
            end
            step();
        end
        exp_ret += 1;
        tests++;
        if (state !== 4'd0 || retired !== exp_ret[31:0]) begin
            fails++;
            $display("FAIL sw_wait_done: state=%0d retired=%0d want 0,%0d", state, retired, exp_ret);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_beq_j();
        test_sw_r_addi();
        test_illegal();
`ifdef MULTICYCLE_MEM_WAIT_EN
        test_fetch_wait();
        test_sw_wait();
`endif
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore state-machine controller that sequences the team's MIPS datapath in multicycle form: one instruction takes 3–5 clocks through fetch, decode, execute, memory and writeback. Driven by the opcode field latched in the instruction register. Emits every datapath select and enable (PC, IR, memory, register file, ALU operand muxes, ALU op class). Also keeps a retired-instruction counter and a sticky illegal-opcode flag for the testbench.

## Interface

Parameters:
- COUNT_W, 32, width of retired-instruction counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-low
- opcode  input  6  instruction[31:26] from the instruction register
- mem_ready  input  1  memory access completes this cycle (used only with MULTICYCLE_MEM_WAIT_EN)
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero
- pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target
- ior_d  output  1  memory address: 0 PC, 1 ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- reg_dst  output  1  write register: 0 rt, 1 rd
- mem_to_reg  output  1  writeback data: 0 ALUOut, 1 MDR
- reg_write  output  1  register file write enable
- alu_src_a  output  1  0 PC, 1 register A
- alu_src_b  output  2  00 register B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  output  2  00 add, 01 subtract, 10 use funct, 11 unused
- state  output  4  current state encoding (debug)
- retired  output  COUNT_W  instructions completed since reset
- illegal_op  output  1  sticky: unsupported opcode decoded

## Operation

- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- State encodings and outputs (unlisted outputs are 0):
  - FETCH=0: mem_read, ir_write, pc_write; alu_src_b=01.
  - DECODE=1: alu_src_b=11.
  - MEM_ADDR=2: alu_src_a, alu_src_b=10.
  - MEM_READ=3: mem_read, ior_d.
  - MEM_WB=4: mem_to_reg, reg_write.
  - MEM_WRITE=5: mem_write, ior_d.
  - R_EXEC=6: alu_src_a, alu_op=10.
  - R_WB=7: reg_dst, reg_write.
  - BRANCH=8: alu_src_a, alu_op=01, pc_write_cond, pc_source=01.
  - JUMP=9: pc_write, pc_source=10.
  - ADDI_EXEC=10: alu_src_a, alu_src_b=10.
  - ADDI_WB=11: reg_write.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEM_ADDR (lw/sw), R_EXEC, BRANCH, JUMP or ADDI_EXEC.
  - MEM_ADDR→MEM_READ (lw) or MEM_WRITE (sw); MEM_READ→MEM_WB.
  - R_EXEC→R_WB; ADDI_EXEC→ADDI_WB.
  - MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB→FETCH.
  - Encodings 12–15 are unreachable; if entered, next state is FETCH with all outputs 0.
- Opcode is sampled only in DECODE and MEM_ADDR.
- Illegal opcode in DECODE: illegal_op sets, next state is FETCH, retired does not increment.
- retired increments by 1 on the final-state cycle of each instruction (states 4, 5, 7, 8, 9, 11) and wraps modulo 2^COUNT_W.
- Reset (rst=0 at a clk edge):
  - state←FETCH, retired←0, illegal_op←0.
  - While rst=0, all control outputs are forced to 0.
  - Reset mid-instruction abandons the instruction with no writeback.

## Timing

- Outputs are combinational decode of the state register plus rst (and mem_ready when wait is enabled). No input-to-output path from opcode.
- Latency without wait states: lw 5 cycles, sw/R/addi 4, beq/j 3.
- First FETCH cycle is the first clk edge where rst=1 is sampled plus zero cycles: outputs go active immediately after reset deasserts.
- retired and illegal_op update on the clk edge ending the qualifying cycle.

## Configuration

- MULTICYCLE_MEM_WAIT_EN defined:
  - FETCH, MEM_READ and MEM_WRITE hold their state while mem_ready=0.
  - In FETCH, ir_write and pc_write assert only in the cycle mem_ready=1; mem_read is held throughout.
  - In MEM_WRITE, mem_write is held throughout; retired increments only on the mem_ready=1 cycle.
- Undefined: mem_ready is ignored and every state lasts exactly one cycle.

## Test plan

- Reset: rst=0 for 2 cycles mid-R_EXEC → state=0, retired=0, illegal_op=0, all controls 0; after release, state=0 with mem_read=ir_write=pc_write=1.
- lw (100011): state sequence 0,1,2,3,4 → MEM_WB shows mem_to_reg=1, reg_write=1, reg_dst=0; retired 0→1.
- beq then j: sequences 0,1,8 and 0,1,9 → pc_source 01 with pc_write_cond=1, then pc_source 10 with pc_write=1; retired=2 after 6 cycles.
- Illegal opcode 111111 → 0,1,0; illegal_op=1 and stays 1 through a following addi (0,1,10,11); retired counts only the addi.
- With MULTICYCLE_MEM_WAIT_EN and mem_ready=0 for 3 cycles in FETCH → state stays 0, ir_write=0 for 3 cycles, 1 on the 4th.
- With MULTICYCLE_MEM_WAIT_EN, sw with mem_ready=0 for 2 cycles in MEM_WRITE → state stays 5, mem_write held for 3 cycles; retired increments once.
- COUNT_W=4: run 16 R-type instructions → retired wraps 15→0.
